// File: rtl/pwm_multi_servo_pkg.sv
// Shared constants and helpers for the multi-channel servo PWM block.
// Default servo window: 80-tick period (20 ms at 0.25 ms/tick), 4..8 tick pulses.
package pwm_multi_servo_pkg;

    localparam int DEF_NUM_CH       = 4;
    localparam int DEF_PERIOD_TICKS = 80;
    localparam int DEF_CMP_W        = 7;
    localparam int DEF_MIN_TICKS    = 4;
    localparam int DEF_MAX_TICKS    = 8;
    localparam int CNT_W            = $clog2(DEF_PERIOD_TICKS);

    // Channel index width; a single channel still needs a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // 0 parks the channel; anything else is forced into [min_ticks, max_ticks].
    function automatic int clamp_width(input int value, input int min_ticks, input int max_ticks);
        if (value == 0)
            return 0;
        else if (value < min_ticks)
            return min_ticks;
        else if (value > max_ticks)
            return max_ticks;
        return value;
    endfunction

endpackage

// File: rtl/pwm_multi_servo_if.sv
// Load-side bus between the control FSM (master) and the servo PWM block (slave).
// load is a one-clk strobe; load_err answers one clk later; pending is level status.
interface pwm_multi_servo_if #(
    parameter int NUM_CH = pwm_multi_servo_pkg::DEF_NUM_CH,
    parameter int CMP_W  = pwm_multi_servo_pkg::DEF_CMP_W
);
    import pwm_multi_servo_pkg::*;

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic              load;
    logic [CH_W-1:0]   load_ch;
    logic [CMP_W-1:0]  load_value;
    logic              load_err;
    logic [NUM_CH-1:0] pending;

    modport master (output load, load_ch, load_value, input load_err, pending);
    modport slave  (input load, load_ch, load_value, output load_err, pending);

endinterface

// File: rtl/pwm_multi_servo_channel.sv
// One servo channel: double-buffered compare (shadow -> active on wrap) and output register.
// pwm_out follows cnt by one clk; no backpressure, writes are always accepted.
module pwm_servo_channel
    import pwm_multi_servo_pkg::*;
#(
    parameter int CW = CNT_W,
    parameter int VW = DEF_CMP_W
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CW-1:0] cnt,
    input  logic          wrap,
    input  logic          wr_en,
    input  logic [VW-1:0] wr_value,
    input  logic          ch_en,
    output logic          pending,
    output logic          pwm_out
);

    localparam int XW = (CW > VW) ? CW : VW;

    logic [VW-1:0] shadow;
    logic [VW-1:0] active;
    logic [XW-1:0] cnt_x;
    logic [XW-1:0] act_x;

    assign cnt_x = XW'(cnt);
    assign act_x = XW'(active);

    // A write landing on the wrap clk goes to shadow only; active takes the old shadow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
            pwm_out <= 1'b0;
        end else begin
            if (wrap)
                active <= shadow;
            if (wr_en)
                shadow <= wr_value;
            if (wr_en)
                pending <= 1'b1;
            else if (wrap)
                pending <= 1'b0;
            pwm_out <= ch_en && (cnt_x < act_x);
        end
    end

endmodule

// File: rtl/pwm_multi_servo.sv
// Multi-channel servo PWM: shared period counter, per-channel clamped double-buffered compare.
// Outputs registered, one clk behind the counter; loads never stall, bad loads flag load_err.
module pwm_multi_servo
    import pwm_multi_servo_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int PERIOD_TICKS = DEF_PERIOD_TICKS,
    parameter int CMP_W        = DEF_CMP_W,
    parameter int MIN_TICKS    = DEF_MIN_TICKS,
    parameter int MAX_TICKS    = DEF_MAX_TICKS
)(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic [NUM_CH-1:0]  ch_en,
    pwm_multi_servo_if.slave   lif,
    output logic               period_start,
    output logic [NUM_CH-1:0]  pwm_out
);

    localparam int CW = $clog2(PERIOD_TICKS);

    logic [CW-1:0]     cnt;
    logic              wrap;
    logic              bad_ch;
    logic [CMP_W-1:0]  clamped;
    logic [NUM_CH-1:0] wr_en;
    logic [NUM_CH-1:0] pend_w;

    assign wrap    = tick && (cnt == CW'(PERIOD_TICKS - 1));
    assign bad_ch  = 32'(lif.load_ch) >= NUM_CH;
    assign clamped = CMP_W'(clamp_width(int'(lif.load_value), MIN_TICKS, MAX_TICKS));

    always_comb begin
        wr_en = '0;
        if (lif.load && !bad_ch)
            wr_en[lif.load_ch] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            period_start <= 1'b0;
            lif.load_err <= 1'b0;
        end else begin
            if (tick)
                cnt <= wrap ? '0 : cnt + CW'(1);
            period_start <= wrap;
            lif.load_err <= lif.load && (bad_ch || (clamped != lif.load_value));
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_servo_channel #(
            .CW (CW),
            .VW (CMP_W)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .cnt      (cnt),
            .wrap     (wrap),
            .wr_en    (wr_en[i]),
            .wr_value (clamped),
            .ch_en    (ch_en[i]),
            .pending  (pend_w[i]),
            .pwm_out  (pwm_out[i])
        );
    end

    assign lif.pending = pend_w;

endmodule

// File: tb/tb_pwm_multi_servo.sv
// Bench for pwm_multi_servo: per-cycle model comparison plus directed pulse-width checks.
module tb_pwm_multi_servo;
    import pwm_multi_servo_pkg::*;

    localparam int N    = 4;
    localparam int P    = 80;
    localparam int MINT = 4;
    localparam int MAXT = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         tick = 1'b0;
    logic [N-1:0] ch_en = '1;
    logic         period_start;
    logic [N-1:0] pwm_out;
    logic [2:0]   ch_en2 = '1;
    logic         ps2;
    logic [2:0]   pwm2;

    int   tests = 0;
    int   fails = 0;
    bit   cmp_on = 1'b0;
    logic [1:0] phase = '0;
    int   hi[N];

    pwm_multi_servo_if #(.NUM_CH(N), .CMP_W(7)) lif();
    pwm_multi_servo_if #(.NUM_CH(3), .CMP_W(7)) lif2();

    pwm_multi_servo #(.NUM_CH(N), .PERIOD_TICKS(P), .CMP_W(7), .MIN_TICKS(MINT), .MAX_TICKS(MAXT)) dut (
        .clk(clk), .reset_n(reset_n), .tick(tick), .ch_en(ch_en), .lif(lif),
        .period_start(period_start), .pwm_out(pwm_out));

    // Three-channel instance: load_ch=3 is representable but out of range.
    pwm_multi_servo #(.NUM_CH(3), .PERIOD_TICKS(P), .CMP_W(7), .MIN_TICKS(MINT), .MAX_TICKS(MAXT)) dut2 (
        .clk(clk), .reset_n(reset_n), .tick(tick), .ch_en(ch_en2), .lif(lif2),
        .period_start(ps2), .pwm_out(pwm2));

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tick  = (phase == 2'd3);
            phase = phase + 2'd1;
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int mclamp(input int v);
        if (v == 0) return 0;
        if (v < MINT) return MINT;
        if (v > MAXT) return MAXT;
        return v;
    endfunction

    // Behavioural model: period position, buffered widths, and what each pin must show.
    int           m_cnt = 0;
    int           m_sh[N];
    int           m_act[N];
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_pwm = '0;
    logic         m_ps = 1'b0;
    logic         m_err = 1'b0;
    bit           m_wrap;
    int           m_v;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt = 0; m_pend = '0; m_pwm = '0; m_ps = 1'b0; m_err = 1'b0;
            for (int c = 0; c < N; c++) begin m_sh[c] = 0; m_act[c] = 0; end
        end else begin
            m_wrap = tick && (m_cnt == P - 1);
            for (int c = 0; c < N; c++) m_pwm[c] = ch_en[c] && (m_cnt < m_act[c]);
            m_ps  = m_wrap;
            m_err = 1'b0;
            if (m_wrap)
                for (int c = 0; c < N; c++) begin m_act[c] = m_sh[c]; m_pend[c] = 1'b0; end
            if (lif.load) begin
                m_v   = mclamp(int'(lif.load_value));
                m_err = (m_v != int'(lif.load_value));
                m_sh[lif.load_ch]   = m_v;
                m_pend[lif.load_ch] = 1'b1;
            end
            if (tick) m_cnt = (m_cnt + 1) % P;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("pwm_out",      int'(pwm_out),      int'(m_pwm));
            chk("pending",      int'(lif.pending),  int'(m_pend));
            chk("period_start", int'(period_start), int'(m_ps));
            chk("load_err",     int'(lif.load_err), int'(m_err));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic do_load(input int ch, input int val, output bit err);
        @(posedge clk); #2;
        lif.load = 1'b1; lif.load_ch = 2'(ch); lif.load_value = 7'(val);
        @(posedge clk); #2;
        lif.load = 1'b0;
        @(negedge clk);
        err = lif.load_err;
    endtask

    task automatic wait_ps();
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (period_start) return;
        end
        chk("wait_period_start_timeout", 0, 1);
    endtask

    // Call on a period_start negedge; counts high clks per channel for one full period.
    task automatic count_period();
        for (int c = 0; c < N; c++) hi[c] = 0;
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < N; c++) if (pwm_out[c]) hi[c]++;
            @(negedge clk);
            if (period_start) return;
        end
        chk("count_period_timeout", 0, 1);
    endtask

    bit e1, e2;
    int nt, nh;
    bit found;

    initial begin
        lif.load = 1'b0; lif.load_ch = '0; lif.load_value = '0;
        lif2.load = 1'b0; lif2.load_ch = '0; lif2.load_value = '0;
        cyc(3);
        cmp_on = 1'b1;
        @(negedge clk);
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_pending", int'(lif.pending), 0);
        chk("reset_ps", int'(period_start), 0);
        cyc(1);
        reset_n = 1'b1;

        // 1: ch0=6, parked for the first period, then 6 ticks wide
        do_load(0, 6, e1);
        chk("t1_err", int'(e1), 0);
        chk("t1_pending_before_wrap", int'(lif.pending[0]), 1);
        wait_ps();
        chk("t1_pending_after_wrap", int'(lif.pending[0]), 0);
        count_period();
        chk("t1_ch0_high_clks", hi[0], 24);

        // 2: below-min and above-max values are clamped with an error pulse each
        do_load(1, 2, e1);
        do_load(2, 20, e2);
        chk("t2_err_ch1", int'(e1), 1);
        chk("t2_err_ch2", int'(e2), 1);
        wait_ps();
        count_period();
        chk("t2_ch0_high_clks", hi[0], 24);
        chk("t2_ch1_high_clks", hi[1], 16);
        chk("t2_ch2_high_clks", hi[2], 32);

        // 3: load on the wrap clk applies one period late
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(posedge clk); #2;
            if (tick && m_cnt == P - 1) found = 1'b1;
        end
        chk("t3_found_wrap_clk", int'(found), 1);
        lif.load = 1'b1; lif.load_ch = 2'd3; lif.load_value = 7'd5;
        @(posedge clk); #2;
        lif.load = 1'b0;
        @(negedge clk);
        chk("t3_ps_on_load_clk", int'(period_start), 1);
        chk("t3_pending_across_wrap", int'(lif.pending[3]), 1);
        count_period();
        chk("t3_ch3_old_value", hi[3], 0);
        chk("t3_pending_cleared", int'(lif.pending[3]), 0);
        count_period();
        chk("t3_ch3_new_value", hi[3], 20);

        // 4: last write wins, 0 parks the channel without error
        do_load(0, 7, e1);
        do_load(0, 0, e2);
        chk("t4_err_7", int'(e1), 0);
        chk("t4_err_0", int'(e2), 0);
        wait_ps();
        count_period();
        chk("t4_ch0_parked", hi[0], 0);

        // 5: out-of-range channel on the 3-channel instance
        @(posedge clk); #2;
        lif2.load = 1'b1; lif2.load_ch = 2'd3; lif2.load_value = 7'd6;
        @(posedge clk); #2;
        lif2.load = 1'b0;
        @(negedge clk);
        chk("t5_bad_ch_err", int'(lif2.load_err), 1);
        chk("t5_bad_ch_pending", int'(lif2.pending), 0);
        @(posedge clk); #2;
        lif2.load = 1'b1; lif2.load_ch = 2'd2; lif2.load_value = 7'd6;
        @(posedge clk); #2;
        lif2.load = 1'b0;
        @(negedge clk);
        chk("t5_good_ch_err", int'(lif2.load_err), 0);
        chk("t5_good_ch_pending", int'(lif2.pending), 4);

        // 5: ch_en drop mid-pulse
        do_load(0, 6, e1);
        wait_ps();
        cyc(3);
        ch_en = 4'b1110;
        @(negedge clk);
        chk("t5_still_high_before_edge", int'(pwm_out[0]), 1);
        @(negedge clk);
        chk("t5_low_after_disable", int'(pwm_out[0]), 0);
        cyc(8);
        ch_en = 4'b1111;
        wait_ps();
        count_period();
        chk("t5_ch0_after_reenable", hi[0], 24);

        // 6: asynchronous reset mid-pulse
        do_load(1, 5, e1);
        chk("t6_pending_pre_reset", int'(lif.pending[1]), 1);
        chk("t6_ch0_high_pre_reset", int'(pwm_out[0]), 1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_pwm", int'(pwm_out), 0);
        chk("t6_async_pending", int'(lif.pending), 0);
        chk("t6_async_ps", int'(period_start), 0);
        cyc(3);
        reset_n = 1'b1;
        nt = 0; nh = 0; found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(posedge clk);
            if (tick) nt++;
            @(negedge clk);
            if (pwm_out != '0) nh++;
            if (period_start) found = 1'b1;
        end
        chk("t6_ps_found", int'(found), 1);
        chk("t6_ticks_to_ps", nt, P);
        chk("t6_no_pulse_after_reset", nh, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
